// File: rtl/mips_pkg.sv
// mips_pkg: state codes, opcode/funct constants and ALUCon codes shared by the
// multi-cycle controller and the ALU.
package mips_pkg;
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    // ALUOP_NONE yields ALUCon 0000 in states that do not use the ALU
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;
endpackage

// File: rtl/alu_con_dec.sv
// alu_con_dec: maps the controller's alu_op and the R-type funct field to an
// ALUCon code, flagging unknown funct values.
module alu_con_dec
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] ALUCon,
    output logic       bad_funct
);
    always_comb begin
        bad_funct = 1'b0;
        ALUCon = 4'b0000;
        case (alu_op)
            ALUOP_ADD: ALUCon = ALU_ADD;
            ALUOP_SUB: ALUCon = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  ALUCon = ALU_ADD;
                    FN_SUB:  ALUCon = ALU_SUB;
                    FN_AND:  ALUCon = ALU_AND;
                    FN_OR:   ALUCon = ALU_OR;
                    FN_SLT:  ALUCon = ALU_SLT;
                    default: begin
                        ALUCon = ALU_ADD;
                        bad_funct = 1'b1;
                    end
                endcase
            end
            default: ALUCon = 4'b0000;
        endcase
    end
endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: Moore FSM controller for a multi-cycle MIPS datapath.
// Define MIPS_ADDI_EN to add the ADDIEX/ADDIWB path for addi.
module mips_mc_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] ALUCon,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       pc_en,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       illegal_op
);
    state_t state_q, state_d;
    logic illegal_q, illegal_d;
    logic [1:0] alu_op;
    logic bad_funct;
    logic mem_write_c, ir_write_c, reg_write_c, pc_write, pc_write_cond;

    alu_con_dec u_dec (
        .alu_op   (alu_op),
        .funct    (funct),
        .ALUCon   (ALUCon),
        .bad_funct(bad_funct)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        illegal_d = illegal_q;
        alu_op = ALUOP_NONE;
        iord = 1'b0;
        mem_read = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c = 1'b0;
        reg_dst = 1'b0;
        mem_to_reg = 1'b0;
        reg_write_c = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        pc_src = 2'b00;
        pc_write = 1'b0;
        pc_write_cond = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write_c = 1'b1;
                alu_src_b = 2'b01;
                alu_op = ALUOP_ADD;
                pc_write = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      illegal_d = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op = ALUOP_ADD;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_c = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                iord = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op = ALUOP_FUNCT;
                illegal_d = illegal_q | bad_funct;
                state_d = S_RWB;
            end
            S_RWB: begin
                reg_write_c = 1'b1;
                reg_dst = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op = ALUOP_SUB;
                pc_src = 2'b01;
                pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_write = 1'b1;
            end
`ifdef MIPS_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op = ALUOP_ADD;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: reg_write_c = 1'b1;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Reset already forces FETCH; the gating keeps FETCH's strobes quiet while it is held
    assign ir_write   = ir_write_c & ~reset;
    assign reg_write  = reg_write_c & ~reset;
    assign mem_write  = mem_write_c & ~reset;
    assign pc_en      = (pc_write | (pc_write_cond & zero)) & ~reset;
    assign state      = state_q;
    assign illegal_op = illegal_q;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: random instruction stream against a per-instruction reference
// model; expected cycle vectors are queued and a negedge monitor compares them.
module tb_mips_mc_ctrl;
    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic iord, mrd, mwr, irw, rdst, m2r, rw, asa;
        logic [1:0] asb, psrc;
        logic pcen, ill;
    } ovec_t;

    logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic [3:0] ALUCon, state;
    logic iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, illegal_op;
    logic [1:0] alu_src_b, pc_src;

    int vectors = 0, miscompares = 0;
    ovec_t q[$];
    string qn[$];
    logic flag = 1'b0;

    mips_mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .ALUCon(ALUCon), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .pc_en(pc_en),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .state(state), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // {bad, code} for an R-type funct
    function automatic logic [4:0] fdec(input logic [5:0] fn);
        case (fn)
            6'b100000: return 5'b0_0010;
            6'b100010: return 5'b0_0110;
            6'b100100: return 5'b0_0000;
            6'b100101: return 5'b0_0001;
            6'b101010: return 5'b0_0111;
            default:   return 5'b1_0010;
        endcase
    endfunction

    function automatic ovec_t expv(input int s, input logic z, input logic [5:0] fn, input logic il);
        ovec_t e;
        logic [4:0] fd;
        fd = fdec(fn);
        e = '0;
        e.st = 4'(s);
        e.ill = il;
        case (s)
            0: begin e.mrd = 1; e.irw = 1; e.asb = 2'b01; e.alu = 4'b0010; e.pcen = 1; end
            1: begin e.asb = 2'b11; e.alu = 4'b0010; end
            2: begin e.asa = 1; e.asb = 2'b10; e.alu = 4'b0010; end
            3: begin e.mrd = 1; e.iord = 1; end
            4: begin e.rw = 1; e.m2r = 1; end
            5: begin e.mwr = 1; e.iord = 1; end
            6: begin e.asa = 1; e.alu = fd[3:0]; end
            7: begin e.rw = 1; e.rdst = 1; end
            8: begin e.asa = 1; e.alu = 4'b0110; e.psrc = 2'b01; e.pcen = z; end
            9: begin e.psrc = 2'b10; e.pcen = 1; end
            10: begin e.asa = 1; e.asb = 2'b10; e.alu = 4'b0010; end
            11: e.rw = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int cut);
        int seq[$];
        int n;
        opcode = op; funct = fn; zero = z;
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b000100: seq = '{0, 1, 8};
            6'b000010: seq = '{0, 1, 9};
`ifdef MIPS_ADDI_EN
            6'b001000: seq = '{0, 1, 10, 11};
`endif
            default:   seq = '{0, 1};
        endcase
        n = seq.size();
        while (cut > 0 && seq.size() > cut) seq.delete(seq.size() - 1);
        foreach (seq[i]) begin
            q.push_back(expv(seq[i], z, fn, flag));
            qn.push_back($sformatf("op%b_fn%b_s%0d", op, fn, seq[i]));
            if (seq[i] == 1 && n == 2) flag = 1'b1;
            if (seq[i] == 6 && fdec(fn)[4]) flag = 1'b1;
        end
        repeat (seq.size()) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", nm, act, req);
        end
    endtask

    // Assert reset mid-MEMRD of a lw and check the asynchronous response
    task automatic reset_pulse();
        ovec_t e;
        issue(6'b100011, 6'd0, 1'b0, 3);
        #1 reset = 1'b1;
        flag = 1'b0;
        e = expv(0, 1'b0, 6'd0, 1'b0);
        e.irw = 0;
        e.pcen = 0;
        q.push_back(e);
        qn.push_back("reset_held");
        #1;
        chk("rst_state", {4'd0, state}, 8'd0);
        chk("rst_wen", {4'd0, ir_write, pc_en, reg_write, mem_write}, 8'd0);
        chk("rst_illegal", {7'd0, illegal_op}, 8'd0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            ovec_t e, a;
            string nm;
            e = q.pop_front();
            nm = qn.pop_front();
            a = {state, ALUCon, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, pc_src, pc_en, illegal_op};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s got %h expected %h", nm, a, e);
            end
        end
    end

    initial begin
        logic [5:0] op, fn;
        logic [5:0] fns[5];
        int r;
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        #3;
        chk("init_state", {4'd0, state}, 8'd0);
        chk("init_wen", {4'd0, ir_write, pc_en, reg_write, mem_write}, 8'd0);
        chk("init_illegal", {7'd0, illegal_op}, 8'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        issue(6'b100011, 6'd0, 1'b0, 0);
        issue(6'b000000, 6'b101010, 1'b0, 0);
        issue(6'b000100, 6'd0, 1'b1, 0);
        issue(6'b000100, 6'd0, 1'b0, 0);
        issue(6'b001000, 6'd0, 1'b0, 0);
        issue(6'b111111, 6'd0, 1'b0, 0);
        issue(6'b000010, 6'd0, 1'b1, 0);
        reset_pulse();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            case (r)
                0, 1: op = 6'b100011;
                2: op = 6'b101011;
                3, 4: op = 6'b000000;
                5: op = 6'b000100;
                6: op = 6'b000010;
                7: op = 6'b001000;
                8: op = 6'b111111;
                default: op = 6'($urandom);
            endcase
            issue(op, fn, 1'($urandom), 0);
            if (i == 150 || i == 300) reset_pulse();
        end
        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
